// File: rtl/io_shield_input_reader.sv
// -----------------------------------------------------------------------------
// io_shield_input_reader
//
// Input side of the IO Shield. The block samples the push buttons and DIP
// switches through 2-FF synchronisers, then debounces them on a slow sample
// tick. It reports debounced levels, one-cycle edge pulses and a valid/ready
// stream of button events.
//
// Optional feature macro: IO_INPUT_RELEASE_EVT_EN
//   Defined   : button releases are also queued as events (evt_release = 1).
//   Undefined : only presses are queued and evt_release is tied to 0.
//               The btn_release pulses are generated in both builds.
//
// Parameters
//   N_BTN          number of push buttons
//   N_DIP          number of DIP switches
//   TICK_CYCLES    clk cycles per debounce sample tick (>= 2)
//   STABLE_SAMPLES identical consecutive samples needed to change a level (>= 2)
//
// Ports
//   clk, rst_n   clock and asynchronous active-low reset
//   io_button    raw buttons, active-high, asynchronous
//   io_dip       raw DIP switches, active-high, asynchronous
//   ready        priming done; pulses, events and overflow enabled
//   btn_state    debounced button levels
//   btn_press    one-cycle pulse for each debounced 0->1 button edge
//   btn_release  one-cycle pulse for each debounced 1->0 button edge
//   dip_state    debounced DIP levels
//   dip_changed  one-cycle pulse for each debounced DIP edge
//   evt_valid    event presented
//   evt_ready    consumer accepts the presented event
//   evt_btn      button index of the presented event
//   evt_release  1 = release event (only with IO_INPUT_RELEASE_EVT_EN)
//   evt_overflow sticky flag: an event was dropped
// -----------------------------------------------------------------------------
module io_shield_input_reader #(
  parameter int N_BTN          = 5,
  parameter int N_DIP          = 24,
  parameter int TICK_CYCLES    = 100000,
  parameter int STABLE_SAMPLES = 8,
  localparam int BTN_W         = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] io_button,
  input  logic [N_DIP-1:0] io_dip,
  output logic             ready,
  output logic [N_BTN-1:0] btn_state,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_DIP-1:0] dip_state,
  output logic [N_DIP-1:0] dip_changed,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [BTN_W-1:0] evt_btn,
  output logic             evt_release,
  output logic             evt_overflow
);

  localparam int N_IN    = N_BTN + N_DIP;
  localparam int CNT_W   = $clog2(TICK_CYCLES);
  localparam int PRIME_W = $clog2(STABLE_SAMPLES);
  localparam logic [CNT_W-1:0]   TICK_LAST  = CNT_W'(TICK_CYCLES - 1);
  localparam logic [PRIME_W-1:0] PRIME_LAST = PRIME_W'(STABLE_SAMPLES - 1);

  // Buttons occupy the low bits and DIPs the high bits of every per-input
  // vector. One debounce datapath then serves both kinds of input.
  logic [N_IN-1:0] raw;
  logic [N_IN-1:0] sync1;
  logic [N_IN-1:0] sync2;

  assign raw = {io_dip, io_button};

  // Two-flop synchroniser on every raw input bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Sample-tick prescaler. The tick is high in the cycle the count sits at its
  // last value, and the count wraps in that same cycle.
  logic [CNT_W-1:0] presc;
  logic             tick;

  assign tick = (presc == TICK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + CNT_W'(1);
  end

  // Priming: count the first STABLE_SAMPLES ticks. During those ticks the
  // histories fill and levels settle, but edges are not reported. As a result,
  // switches that are already on at reset do not produce events.
  logic [PRIME_W-1:0] prime_cnt;
  logic               primed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prime_cnt <= '0;
      primed    <= 1'b0;
    end else if (tick && !primed) begin
      if (prime_cnt == PRIME_LAST) primed <= 1'b1;
      else                         prime_cnt <= prime_cnt + PRIME_W'(1);
    end
  end

  assign ready = primed;

  // Debounce. Each input keeps only its previous STABLE_SAMPLES-1 samples.
  // The window under test is that stored history plus the current sample,
  // which equals the full history after the shift.
  logic [N_IN-1:0][STABLE_SAMPLES-2:0] hist;
  logic [N_IN-1:0][STABLE_SAMPLES-1:0] window;
  logic [N_IN-1:0]                     level;
  logic [N_IN-1:0]                     level_next;
  logic [N_IN-1:0]                     rise;
  logic [N_IN-1:0]                     fall;

  always_comb begin
    window     = '0;
    level_next = level;
    for (int i = 0; i < N_IN; i++) begin
      window[i] = {hist[i], sync2[i]};
      if (&window[i])       level_next[i] = 1'b1;
      else if (~|window[i]) level_next[i] = 1'b0;
    end
  end

  assign rise = level_next & ~level;
  assign fall = level & ~level_next;

  // Histories, levels and edge pulses all update on the tick. A pulse
  // therefore appears in the first cycle in which its new level is visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist        <= '0;
      level       <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      dip_changed <= '0;
    end else begin
      btn_press   <= '0;
      btn_release <= '0;
      dip_changed <= '0;
      if (tick) begin
        for (int i = 0; i < N_IN; i++) begin
          hist[i] <= window[i][STABLE_SAMPLES-2:0];
        end
        level <= level_next;
        if (primed) begin
          btn_press   <= rise[N_BTN-1:0];
          btn_release <= fall[N_BTN-1:0];
          dip_changed <= rise[N_IN-1:N_BTN] | fall[N_IN-1:N_BTN];
        end
      end
    end
  end

  assign btn_state = level[N_BTN-1:0];
  assign dip_state = level[N_IN-1:N_BTN];

  // Event queue: one pending bit per button (and per release when enabled).
  // Pulses only occur after priming, so pending sets are suppressed while
  // priming without any extra gating.
  logic [N_BTN-1:0] pend_press;
  logic [N_BTN-1:0] cap_press;
  logic [BTN_W-1:0] sel;
  logic             found;
  logic             capture;
  logic             lost;
  logic             evt_valid_q;
  logic [BTN_W-1:0] evt_btn_q;

`ifdef IO_INPUT_RELEASE_EVT_EN
  logic [N_BTN-1:0] pend_rel;
  logic [N_BTN-1:0] cap_rel;
  logic             sel_rel;
  logic             evt_rel_q;

  // Select the lowest pending index. For the same index, a press wins over a
  // release. The scan runs from the top down, so the last match is the winner.
  always_comb begin
    found   = 1'b0;
    sel     = '0;
    sel_rel = 1'b0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (pend_rel[i]) begin
        found   = 1'b1;
        sel     = BTN_W'(i);
        sel_rel = 1'b1;
      end
      if (pend_press[i]) begin
        found   = 1'b1;
        sel     = BTN_W'(i);
        sel_rel = 1'b0;
      end
    end
  end

  always_comb begin
    cap_press = '0;
    cap_rel   = '0;
    for (int i = 0; i < N_BTN; i++) begin
      cap_press[i] = capture && !sel_rel && (sel == BTN_W'(i));
      cap_rel[i]   = capture &&  sel_rel && (sel == BTN_W'(i));
    end
  end

  // A pulse that lands on an already-pending bit, where that bit is not being
  // captured this cycle, loses an event.
  assign lost = |(btn_press & pend_press & ~cap_press) |
                |(btn_release & pend_rel & ~cap_rel);

  // A set in the same cycle as a capture of the same bit keeps the bit pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_rel  <= '0;
      evt_rel_q <= 1'b0;
    end else begin
      pend_rel <= (pend_rel & ~cap_rel) | btn_release;
      if (capture) evt_rel_q <= sel_rel;
    end
  end

  assign evt_release = evt_rel_q;
`else
  // Select the lowest pending press index. The scan runs from the top down,
  // so the last match is the winner.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (pend_press[i]) begin
        found = 1'b1;
        sel   = BTN_W'(i);
      end
    end
  end

  always_comb begin
    cap_press = '0;
    for (int i = 0; i < N_BTN; i++) begin
      cap_press[i] = capture && (sel == BTN_W'(i));
    end
  end

  assign lost        = |(btn_press & pend_press & ~cap_press);
  assign evt_release = 1'b0;
`endif

  // Capture happens only while nothing is presented. This guarantees at least
  // one idle cycle between events and keeps evt_btn stable while it is shown.
  assign capture = !evt_valid_q && found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_press   <= '0;
      evt_valid_q  <= 1'b0;
      evt_btn_q    <= '0;
      evt_overflow <= 1'b0;
    end else begin
      pend_press <= (pend_press & ~cap_press) | btn_press;
      if (capture) begin
        evt_valid_q <= 1'b1;
        evt_btn_q   <= sel;
      end else if (evt_valid_q && evt_ready) begin
        evt_valid_q <= 1'b0;
      end
      if (lost) evt_overflow <= 1'b1;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_btn   = evt_btn_q;

endmodule

// File: tb/tb_io_shield_input_reader.sv
// -----------------------------------------------------------------------------
// tb_io_shield_input_reader
//
// Scoreboard bench for io_shield_input_reader (TICK_CYCLES=4, STABLE_SAMPLES=3).
// Stimulus updates a button/DIP model and pushes the events it expects. A
// monitor pops and compares each accepted event, and counts the edge pulses.
// -----------------------------------------------------------------------------
module tb_io_shield_input_reader;

  localparam int N_BTN = 5;
  localparam int N_DIP = 24;
  localparam int T     = 4;
  localparam int S     = 3;
  localparam int HOLD  = (S + 3) * T;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [4:0]       io_button = '0;
  logic [23:0]      io_dip = '0;
  logic             evt_ready = 1'b0;
  logic             ready;
  logic [4:0]       btn_state;
  logic [4:0]       btn_press;
  logic [4:0]       btn_release;
  logic [23:0]      dip_state;
  logic [23:0]      dip_changed;
  logic             evt_valid;
  logic [2:0]       evt_btn;
  logic             evt_release;
  logic             evt_overflow;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  logic [4:0]  btn_model = '0;
  logic [23:0] dip_model = '0;
  int press_exp = 0, rel_exp = 0, dchg_exp = 0;
  int press_seen = 0, rel_seen = 0, dchg_seen = 0;
  bit rdy_rand = 1'b1;
  bit rdy_force = 1'b0;

  io_shield_input_reader #(
    .N_BTN(N_BTN), .N_DIP(N_DIP), .TICK_CYCLES(T), .STABLE_SAMPLES(S)
  ) dut (
    .clk(clk), .rst_n(rst_n), .io_button(io_button), .io_dip(io_dip),
    .ready(ready), .btn_state(btn_state), .btn_press(btn_press),
    .btn_release(btn_release), .dip_state(dip_state), .dip_changed(dip_changed),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_btn(evt_btn),
    .evt_release(evt_release), .evt_overflow(evt_overflow)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Consumer: evt_ready changes just after each rising edge. It is either
  // random (mostly accepting) or forced by the directed sequence.
  always @(posedge clk) begin
    #1;
    evt_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
  end

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out waiting at %0t", name, $time);
  endtask

  // Monitor: score accepted events, check hold stability and pulse widths,
  // and count the edge pulses.
  logic       prev_hold = 1'b0;
  logic [3:0] prev_evt = '0;
  logic [4:0] prev_press = '0;
  logic [4:0] prev_rel = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold  = 1'b0;
      prev_press = '0;
      prev_rel   = '0;
    end else begin
      if (prev_hold)
        check_output("evt_hold_stable", {evt_valid, evt_btn, evt_release}, {1'b1, prev_evt});
      if (evt_valid && evt_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_event: got btn=%0d rel=%0b, expected none",
                   evt_btn, evt_release);
        end else begin
          check_output("evt_order", {evt_btn, evt_release}, exp_q.pop_front());
        end
      end
      prev_hold = evt_valid && !evt_ready;
      prev_evt  = {evt_btn, evt_release};
      check_output("press_pulse_width", btn_press & prev_press, 0);
      check_output("release_pulse_width", btn_release & prev_rel, 0);
      prev_press = btn_press;
      prev_rel   = btn_release;
      press_seen += $countones(btn_press);
      rel_seen   += $countones(btn_release);
      dchg_seen  += $countones(dip_changed);
    end
  end

  // Model update: each debounced button edge yields its events in ascending
  // index order, and every flipped DIP yields one dip_changed pulse.
  task automatic set_inputs(input logic [4:0] b, input logic [23:0] d);
    for (int i = 0; i < N_BTN; i++) begin
      if (b[i] && !btn_model[i]) begin
        exp_q.push_back(i * 2);
        press_exp++;
      end else if (!b[i] && btn_model[i]) begin
        rel_exp++;
`ifdef IO_INPUT_RELEASE_EVT_EN
        exp_q.push_back(i * 2 + 1);
`endif
      end
    end
    dchg_exp += $countones(d ^ dip_model);
    btn_model = b;
    dip_model = d;
    io_button = b;
    io_dip    = d;
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic settle();
    int n = 0;
    while ((exp_q.size() != 0 || evt_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) bound_fail("drain");
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) bound_fail("ready");
  endtask

  task automatic apply_stimulus(input logic [4:0] b, input logic [23:0] d);
    set_inputs(b, d);
    hold(HOLD);
    settle();
    check_output("btn_state", btn_state, btn_model);
    check_output("dip_state", dip_state, dip_model);
  endtask

  // Watchdog against a hung run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    // Test 1: priming with DIPs already on at reset.
    io_dip    = 24'h00A5F0;
    dip_model = 24'h00A5F0;
    hold(3);
    check_output("reset_ready", ready, 0);
    check_output("reset_evt_valid", evt_valid, 0);
    check_output("reset_dip_state", dip_state, 0);
    check_output("reset_overflow", evt_overflow, 0);
    rst_n = 1'b1;
    wait_ready();
    check_output("prime_dip_state", dip_state, 24'h00A5F0);
    check_output("prime_btn_state", btn_state, 0);
    hold(HOLD);
    check_output("prime_no_dip_changed", dchg_seen, 0);

    // Test 2: single press and its event latency.
    rdy_rand  = 1'b0;
    rdy_force = 1'b1;
    set_inputs(5'b00100, dip_model);
    n = 0;
    while (!btn_press[2] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) bound_fail("t2_press");
    check_output("t2_state_with_pulse", btn_state[2], 1);
    hold(2);
    check_output("t2_evt_n_plus_2", {evt_valid, evt_btn}, {1'b1, 3'd2});
    hold(1);
    check_output("t2_evt_dropped", evt_valid, 0);
    hold(HOLD);
    rdy_rand = 1'b1;
    settle();

    // Test 3: a one-tick glitch does not change the level, and exactly one
    // press follows the sustained high level.
    io_button[0] = 1'b1;
    hold(T);
    io_button[0] = 1'b0;
    hold(T);
    check_output("t3_glitch_state", btn_state[0], 0);
    apply_stimulus(btn_model | 5'b00001, dip_model);

    // Test 4: simultaneous presses while stalled are delivered in ascending order.
    rdy_rand  = 1'b0;
    rdy_force = 1'b0;
    set_inputs(btn_model | 5'b10010, dip_model);
    n = 0;
    while (!evt_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) bound_fail("t4_valid");
    for (int i = 0; i < 10; i++) begin
      check_output("t4_stall_evt", {evt_valid, evt_btn}, {1'b1, 3'd1});
      @(negedge clk);
    end
    rdy_force = 1'b1;
    @(negedge clk);
    rdy_force = 1'b0;
    @(negedge clk);
    check_output("t4_idle_gap", evt_valid, 0);
    @(negedge clk);
    check_output("t4_second_evt", {evt_valid, evt_btn}, {1'b1, 3'd4});
    rdy_rand = 1'b1;
    settle();
    apply_stimulus(5'b00000, dip_model);

    // Test 5: a press on an already-pending bit is lost and sets overflow.
    check_output("t5_overflow_before", evt_overflow, 0);
    rdy_rand  = 1'b0;
    rdy_force = 1'b0;
    set_inputs(5'b00001, dip_model);
    hold(HOLD);
    set_inputs(5'b01001, dip_model);
    hold(HOLD);
    set_inputs(5'b00001, dip_model);
    hold(HOLD);
    io_button    = 5'b01001;
    btn_model[3] = 1'b1;
    press_exp++;
    hold(HOLD);
    check_output("t5_overflow_set", evt_overflow, 1);
    rdy_rand = 1'b1;
    settle();
    check_output("t5_overflow_sticky", evt_overflow, 1);
    apply_stimulus(5'b00000, dip_model);

    // Test 6: press then release (a release event is expected only with the macro).
    apply_stimulus(5'b00100, dip_model);
    apply_stimulus(5'b00000, dip_model);

    // Asynchronous reset mid-operation discards the presented event.
    rdy_rand  = 1'b0;
    rdy_force = 1'b0;
    set_inputs(5'b01000, dip_model);
    hold(HOLD);
    check_output("pre_reset_evt", {evt_valid, evt_btn}, {1'b1, 3'd3});
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("mid_reset_valid", evt_valid, 0);
    check_output("mid_reset_overflow", evt_overflow, 0);
    check_output("mid_reset_ready", ready, 0);
    exp_q.delete();
    hold(3);
    rst_n    = 1'b1;
    rdy_rand = 1'b1;
    wait_ready();
    check_output("reprime_btn_state", btn_state, btn_model);
    check_output("reprime_dip_state", dip_state, dip_model);
    hold(HOLD);

    // Randomised phase: toggle buttons and DIPs and let the model predict.
    for (int k = 0; k < 25; k++) begin
      apply_stimulus(btn_model ^ 5'($urandom_range(1, 31)),
                     dip_model ^ (24'($urandom) & 24'($urandom)));
    end

    check_output("final_overflow_clear", evt_overflow, 0);
    check_output("final_queue_empty", exp_q.size(), 0);
    check_output("press_pulse_count", press_seen, press_exp);
    check_output("release_pulse_count", rel_seen, rel_exp);
    check_output("dip_changed_count", dchg_seen, dchg_exp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
